pipeline_decode_stage: RTL

Parametrised RV32 instruction-decode stage that sits between the IF/ID and EX stages of the pipeline. It holds the architectural register file with write-back bypass, generates sign-extended immediates for every base format, detects load-use hazards, and registers all decoded fields into an ID/EX pipeline register with stall, flush and bubble control. It supersedes the fixed-width decode block and adds RV32E register-count support and illegal-opcode flagging.

---
 rtl/pipeline_decode_stage.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/pipeline_decode_stage.sv
// RV32 instruction-decode stage: register file with optional write-back bypass,
// immediate generation, load-use hazard detection and the ID/EX pipeline register.
module pipeline_decode_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int WB_BYPASS  = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic [31:0]     instruction_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            reg_write_i,
    input  logic [4:0]      write_reg_i,
    input  logic [XLEN-1:0] write_data_i,
    input  logic [4:0]      ex_rd_i,
    input  logic            ex_mem_read_i,
    output logic            load_use_stall_o,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] read_data1_o,
    output logic [XLEN-1:0] read_data2_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [4:0]      rd_o,
    output logic [XLEN-1:0] imm_o,
    output logic [6:0]      opcode_o,
    output logic [2:0]      funct3_o,
    output logic [6:0]      funct7_o,
    output logic            illegal_o
);

    localparam int NREGS = 1 << REG_ADDR_W;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    logic [6:0] opcode;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instruction_i[6:0];
    assign rd     = instruction_i[11:7];
    assign funct3 = instruction_i[14:12];
    assign rs1    = instruction_i[19:15];
    assign rs2    = instruction_i[24:20];
    assign funct7 = instruction_i[31:25];

    logic            known_op;
    logic            rs1_used;
    logic            rs2_used;
    logic            rd_used;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm;
    logic            bad_reg;
    logic            illegal;

    always_comb begin
        known_op = 1'b0;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        rd_used  = 1'b0;
        imm32    = '0;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR: begin
                known_op = 1'b1;
                rs1_used = 1'b1;
                rd_used  = 1'b1;
                imm32    = {{20{instruction_i[31]}}, instruction_i[31:20]};
            end
            OP_STORE: begin
                known_op = 1'b1;
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                imm32    = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
            end
            OP_BRANCH: begin
                known_op = 1'b1;
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                imm32    = {{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                            instruction_i[30:25], instruction_i[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                known_op = 1'b1;
                rd_used  = 1'b1;
                imm32    = {instruction_i[31:12], 12'b0};
            end
            OP_JAL: begin
                known_op = 1'b1;
                rd_used  = 1'b1;
                imm32    = {{11{instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                            instruction_i[20], instruction_i[30:21], 1'b0};
            end
            OP_OP: begin
                known_op = 1'b1;
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                rd_used  = 1'b1;
            end
            default: ;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

    // A reduced register file cannot name x16..x31, so such fields are illegal
    // and such write-backs are dropped.
    logic wr_in_range;
    generate
        if (REG_ADDR_W < 5) begin : g_small_rf
            assign bad_reg     = (rs1_used & rs1[4]) | (rs2_used & rs2[4]) | (rd_used & rd[4]);
            assign wr_in_range = (write_reg_i >> REG_ADDR_W) == 5'd0;
        end else begin : g_full_rf
            assign bad_reg     = 1'b0;
            assign wr_in_range = 1'b1;
        end
    endgenerate

    assign illegal = ~known_op | bad_reg;

    assign load_use_stall_o = valid_i & ex_mem_read_i & (ex_rd_i != 5'd0) &
                              ((rs1_used & (ex_rd_i == rs1)) | (rs2_used & (ex_rd_i == rs2)));

    logic [XLEN-1:0]       regs [NREGS];
    logic                  wr_en;
    logic [REG_ADDR_W-1:0] waddr;

    assign waddr = write_reg_i[REG_ADDR_W-1:0];
    assign wr_en = reg_write_i & (write_reg_i != 5'd0) & wr_in_range;

    // Write-back commits regardless of stall/flush; entry 0 is never written.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[waddr] <= write_data_i;
        end
    end

    logic [1:0][XLEN-1:0] rdata;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read
            logic [4:0] src;
            assign src = (gi == 0) ? rs1 : rs2;
            assign rdata[gi] = (src == 5'd0) ? '0 :
                               ((WB_BYPASS != 0) && reg_write_i && (write_reg_i == src)) ? write_data_i :
                               regs[src[REG_ADDR_W-1:0]];
        end
    endgenerate

    // Reset, flush and an unstalled load-use hazard all load a cleared bubble.
    logic bubble;
    assign bubble = rst_i | flush_i | (~stall_i & load_use_stall_o);

    always_ff @(posedge clk_i) begin
        if (bubble) begin
            valid_o      <= 1'b0;
            pc_o         <= '0;
            read_data1_o <= '0;
            read_data2_o <= '0;
            rs1_o        <= '0;
            rs2_o        <= '0;
            rd_o         <= '0;
            imm_o        <= '0;
            opcode_o     <= '0;
            funct3_o     <= '0;
            funct7_o     <= '0;
            illegal_o    <= 1'b0;
        end else if (!stall_i) begin
            valid_o      <= valid_i;
            pc_o         <= pc_i;
            read_data1_o <= rdata[0];
            read_data2_o <= rdata[1];
            rs1_o        <= rs1;
            rs2_o        <= rs2;
            rd_o         <= rd;
            imm_o        <= imm;
            opcode_o     <= opcode;
            funct3_o     <= funct3;
            funct7_o     <= funct7;
            illegal_o    <= illegal & valid_i;
        end
    end

endmodule
